// File: rtl/wb_queue.sv
// Writeback queue between the pipeline result sources and the register file's
// single write port; drains one entry per cycle and forwards pending values.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [AW-1:0]           in_addr,
    input  logic [DW-1:0]           in_data,
    output logic                    in_ready,
    input  logic                    hold,
    output logic                    WE3,
    output logic [AW-1:0]           A3,
    output logic [DW-1:0]           WD3,
    input  logic [AW-1:0]           RA1,
    input  logic [AW-1:0]           RA2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [DW-1:0]           fwd1,
    output logic [DW-1:0]           fwd2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] scan_idx;
    logic          push;
    logic          pop;

    // Drain-side outputs come from registered state and hold only.
    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CW'(DEPTH));
    assign WE3      = !empty && !hold;
    assign A3       = empty ? '0 : addr_q[rd_ptr_q];
    assign WD3      = empty ? '0 : data_q[rd_ptr_q];
    assign count    = count_q;

    // Writes to register 0 complete the handshake but are never queued.
    assign push = in_valid && in_ready && (in_addr != '0);
    assign pop  = WE3;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = in_addr;
            data_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        fwd1     = '0;
        fwd2     = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((RA1 != '0) && (addr_q[scan_idx] == RA1)) begin
                    hit1 = 1'b1;
                    fwd1 = data_q[scan_idx];
                end
                if ((RA2 != '0) && (addr_q[scan_idx] == RA2)) begin
                    hit2 = 1'b1;
                    fwd2 = data_q[scan_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model and an emulated register file.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [AW-1:0]          in_addr;
    logic [DW-1:0]          in_data;
    logic                   in_ready;
    logic                   hold;
    logic                   WE3;
    logic [AW-1:0]          A3;
    logic [DW-1:0]          WD3;
    logic [AW-1:0]          RA1;
    logic [AW-1:0]          RA2;
    logic                   hit1;
    logic                   hit2;
    logic [DW-1:0]          fwd1;
    logic [DW-1:0]          fwd2;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    int checks   = 0;
    int failures = 0;

    entry_t modelQ[$];
    entry_t expWrites[$];
    logic [DW-1:0] rfModel [32] = '{default: '0};
    logic [DW-1:0] rfDut   [32] = '{default: '0};
    int writeCount = 0;

    logic   mPop;
    logic   mPush;
    entry_t mEntry;

    wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_ready (in_ready),
        .hold     (hold),
        .WE3      (WE3),
        .A3       (A3),
        .WD3      (WD3),
        .RA1      (RA1),
        .RA2      (RA2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic h, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
        RA1      = r1;
        RA2      = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain FIFO of pending results. Every accepted result is
    // also queued as an expected register-file write for the monitor.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelQ.delete();
            expWrites.delete();
        end else begin
            mPop  = (modelQ.size() > 0) && !hold;
            mPush = in_valid && (modelQ.size() < DEPTH) && (in_addr != '0);
            if (mPop) begin
                rfModel[modelQ[0].addr] = modelQ[0].data;
                mEntry = modelQ.pop_front();
            end
            if (mPush) begin
                mEntry = '{in_addr, in_data};
                modelQ.push_back(mEntry);
                expWrites.push_back(mEntry);
            end
        end
    end

    // The register file the queue feeds, written on the falling edge.
    always @(negedge clk) begin
        if (WE3 === 1'b1) begin
            rfDut[A3]  <= WD3;
            writeCount <= writeCount + 1;
        end
    end

    // Monitor: compares status, head and forwarding against the model each cycle
    // and retires one expected write whenever the DUT asserts WE3.
    always @(negedge clk) begin
        int     n;
        logic   eh1, eh2;
        logic [DW-1:0] ef1, ef2;
        entry_t got;
        n   = modelQ.size();
        eh1 = 1'b0; eh2 = 1'b0; ef1 = '0; ef2 = '0;
        for (int i = 0; i < n; i++) begin
            if ((RA1 != '0) && (modelQ[i].addr == RA1)) begin eh1 = 1'b1; ef1 = modelQ[i].data; end
            if ((RA2 != '0) && (modelQ[i].addr == RA2)) begin eh2 = 1'b1; ef2 = modelQ[i].data; end
        end
        checkOutput("mon_count",    32'(count),    32'(n));
        checkOutput("mon_empty",    32'(empty),    32'(n == 0));
        checkOutput("mon_in_ready", 32'(in_ready), 32'(n < DEPTH));
        checkOutput("mon_WE3",      32'(WE3),      32'((n > 0) && !hold));
        checkOutput("mon_A3",       32'(A3),       (n > 0) ? 32'(modelQ[0].addr) : 32'd0);
        checkOutput("mon_WD3",      WD3,           (n > 0) ? modelQ[0].data : 32'd0);
        checkOutput("mon_hit1",     32'(hit1),     32'(eh1));
        checkOutput("mon_fwd1",     fwd1,          ef1);
        checkOutput("mon_hit2",     32'(hit2),     32'(eh2));
        checkOutput("mon_fwd2",     fwd2,          ef2);
        if (WE3 === 1'b1) begin
            checkOutput("sb_write_expected", 32'(expWrites.size() != 0), 32'd1);
            if (expWrites.size() != 0) begin
                got = expWrites.pop_front();
                checkOutput("sb_wr_addr", 32'(A3), 32'(got.addr));
                checkOutput("sb_wr_data", WD3, got.data);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wc;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #11;
        checkOutput("rst_count",    32'(count),    32'd0);
        checkOutput("rst_empty",    32'(empty),    32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_WE3",      32'(WE3),      32'd0);
        checkOutput("rst_A3",       32'(A3),       32'd0);
        checkOutput("rst_WD3",      WD3,           32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Single push: visible on the write port the cycle after the edge.
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #5;
        checkOutput("t1_WE3", 32'(WE3), 32'd1);
        checkOutput("t1_A3",  32'(A3),  32'd5);
        checkOutput("t1_WD3", WD3,      32'hDEADBEEF);
        step();
        #5;
        checkOutput("t1_count_after", 32'(count), 32'd0);
        checkOutput("t1_reg5", rfDut[5], 32'hDEADBEEF);

        // Fill under hold, refuse a fifth, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, AW'(i), 32'h100 + i, 1, 0, 0);
            step();
        end
        applyStimulus(1, 9, 32'h999, 1, 0, 0);
        #5;
        checkOutput("t2_full_count",    32'(count),    32'd4);
        checkOutput("t2_full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_full_WE3",      32'(WE3),      32'd0);
        step();
        applyStimulus(0, 0, 0, 1, 0, 0);
        #5;
        checkOutput("t2_fifth_rejected", 32'(count), 32'd4);
        step();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            #5;
            checkOutput("t2_drain_WE3", 32'(WE3), 32'd1);
            checkOutput("t2_drain_A3",  32'(A3),  32'(i));
            checkOutput("t2_drain_WD3", WD3,      32'h100 + i);
            step();
        end
        #5;
        checkOutput("t2_drained", 32'(count), 32'd0);
        step();

        // Duplicate destination: forwarding must return the younger value.
        applyStimulus(1, 7, 32'h11, 1, 7, 0);
        step();
        applyStimulus(1, 7, 32'h22, 1, 7, 0);
        step();
        applyStimulus(0, 0, 0, 1, 7, 0);
        #5;
        checkOutput("t3_hit1", 32'(hit1), 32'd1);
        checkOutput("t3_fwd1", fwd1,      32'h22);
        step();
        applyStimulus(0, 0, 0, 0, 7, 0);
        repeat (3) step();
        #5;
        checkOutput("t3_hit1_after", 32'(hit1), 32'd0);
        checkOutput("t3_fwd1_after", fwd1,      32'd0);
        checkOutput("t3_reg7",       rfDut[7],  32'h22);
        step();

        // Register 0 results are accepted and dropped; RA = 0 never hits.
        applyStimulus(1, 0, 32'hABCD, 0, 0, 0);
        #5;
        checkOutput("t4_in_ready", 32'(in_ready), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #5;
        checkOutput("t4_count", 32'(count), 32'd0);
        checkOutput("t4_WE3",   32'(WE3),   32'd0);
        step();
        applyStimulus(1, 3, 32'h33, 1, 3, 0);
        step();
        applyStimulus(0, 0, 0, 1, 3, 0);
        #5;
        checkOutput("t4_hit1",  32'(hit1), 32'd1);
        checkOutput("t4_hit2",  32'(hit2), 32'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) step();

        // Back-to-back pushes with free draining wrap the pointers.
        wc = writeCount;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, AW'(i), 32'h1000 + i, 0, AW'(i), 0);
            #5;
            checkOutput("t5_count_le1", 32'(count <= 1), 32'd1);
            if (i > 1) checkOutput("t5_WE3", 32'(WE3), 32'd1);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        #5;
        checkOutput("t5_last_WE3", 32'(WE3), 32'd1);
        checkOutput("t5_last_A3",  32'(A3),  32'd10);
        repeat (2) step();
        checkOutput("t5_writes", 32'(writeCount - wc), 32'd10);
        for (int r = 1; r <= 10; r++) checkOutput("t5_reg", rfDut[r], 32'h1000 + r);

        // Asynchronous reset while entries are pending and draining.
        for (int i = 11; i <= 13; i++) begin
            applyStimulus(1, AW'(i), 32'h5000 + i, 1, 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_WE3",      32'(WE3),      32'd0);
        checkOutput("t6_count",    32'(count),    32'd0);
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_empty",    32'(empty),    32'd1);
        wc = writeCount;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (5) step();
        checkOutput("t6_no_writes", 32'(writeCount), 32'(wc));
        checkOutput("t6_reg11",     rfDut[11],       32'd0);

        // Random traffic with a small address space to force duplicates.
        repeat (400) begin
            applyStimulus($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 2) step();
        for (int r = 0; r < 32; r++) checkOutput("rand_regfile", rfDut[r], rfModel[r]);
        checkOutput("rand_sb_empty", 32'(expWrites.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
